dmem_responder: RTL and testbench
=================================

# dmem_responder

Word-addressed data-memory responder that services the scalar load/store functional unit's `dmemREN`/`dmemWEN`/`dmemaddr`/`dmemstore` request interface. It returns `dmemload` with a single-cycle `dhit` after a fixed, parameterised latency. It is the memory-side end of the scalar LS protocol, used in execute-stage testbenches and as the on-chip scratch data memory until the cache hierarchy lands.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width
- `DATA_W`, 32: word width; fixed at 32
- `DEPTH_WORDS`, 1024: number of storage words
- `LATENCY`, 2: cycles from request acceptance to `dhit`; legal range 1..15

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - `CLK`  in  1  clock
  - `nRST`  in  1  asynchronous active-low reset
- Request (from scalar LS):
  - `dmemREN`  in  1  read request, held until `dhit`
  - `dmemWEN`  in  1  write request, held until `dhit`
  - `dmemaddr`  in  ADDR_W  byte address
  - `dmemstore`  in  DATA_W  write data
- Response (to scalar LS):
  - `dmemload`  out  DATA_W  read data, registered
  - `dhit`  out  1  one-cycle completion pulse
  - `derror`  out  1  asserted with `dhit` on a rejected request
  - `busy`  out  1  high in BUSY and HIT

## Operation
- FSM states: IDLE, BUSY, HIT.
- IDLE, with `dmemREN|dmemWEN` high:
  - Capture addr, data and op.
  - Load the counter with `LATENCY-1`.
  - Go to BUSY. When `LATENCY=1`, go directly to HIT.
- BUSY:
  - If `dmemREN|dmemWEN` drops, abort to IDLE. No write, no `dhit`, outputs unchanged.
  - Otherwise decrement the counter. When it reaches 0, go to HIT.
  - Changes to addr or data during BUSY are ignored; the captured values are used.
- Commit happens on the edge entering HIT:
  - Write: `mem[idx] <= store`.
  - Read: `dmemload <= mem[idx]`.
- HIT: `dhit=1` for exactly one cycle, then IDLE.
  - Request signals seen in the cycle after HIT are a new request. The requester must drop `dmemREN`/`dmemWEN` in that cycle unless it intends a new access.
- Index: `idx = dmemaddr[ADDR_W-1:2]`.
- Error conditions, evaluated at capture:
  - `dmemaddr[1:0] != 0`
  - `idx >= DEPTH_WORDS`
  - `dmemREN & dmemWEN` both high
- Error handling: the request still takes the full latency. Then `dhit=1`, `derror=1` and `dmemload <= 0`; memory is not modified.
- `dmemload` holds its last value across writes and idle cycles. It changes only on a read or error completion.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values: state IDLE; `dmemload=0`, `dhit=0`, `derror=0`, `busy=0`; counter 0.
- Reset mid-operation: return to IDLE immediately and discard the pending write. Memory is unaffected except by writes already committed.
- Latency: a request first visible in cycle t produces `dhit` in cycle t+LATENCY. `dmemload` is valid in that same cycle.
- Throughput: one access per LATENCY+1 cycles when back-to-back.
- A read issued right after a write's HIT to the same address returns the new data.
- `dhit` and `derror` are registered state decodes, with no combinational path from the inputs.

## Structure
- Shared package `datapath_types`, holding:
  - `typedef enum logic [1:0] {DMEM_IDLE, DMEM_BUSY, DMEM_HIT} dmem_state_t`
  - `word_t` (32-bit)
  - The error-cause encoding, used for assertions.
- Sub-module `dmem_array`:
  - `DEPTH_WORDS` × 32 storage.
  - Synchronous write with enable, combinational read.
  - Keeps the FSM synthesisable against an SRAM macro later.
- Top level: FSM, latency counter, request capture registers, error check, output registers.

## Test plan
All scenarios use `LATENCY=2` and `DEPTH_WORDS=1024` unless stated otherwise.
- Reset: pulse `nRST` low while in BUSY with a pending write of `0x12345678` to `0x40` -> all outputs 0, no `dhit`, and a later read of `0x40` does not return `0x12345678` unless it was previously written.
- Write then read: WEN, `0x10`, `0xDEADBEEF` at cycle 0 -> `dhit` only in cycle 2. Then REN `0x10` in cycle 3 -> `dhit` in cycle 5 with `dmemload=0xDEADBEEF`, `derror=0`.
- Abort (`LATENCY=3`): write `0xAAAA5555` to `0x20` after it holds `0x11111111`, drop WEN in cycle 1 -> no `dhit`; a read of `0x20` returns `0x11111111`.
- Errors:
  - REN `0x13` -> `dhit`+`derror` in cycle 2, `dmemload=0`.
  - REN `0x1000` -> `derror`.
  - REN+WEN at `0x0` -> `derror`, with `mem[0]` unchanged.
- Back-to-back (`LATENCY=1`): alternating writes and reads to `0x0`/`0x4` held continuously -> `dhit` every second cycle, all data correct, `busy` toggling accordingly.

Source files
------------

// File: rtl/datapath_types.sv
// datapath_types: shared state, word and error-cause types for the data-memory path
package datapath_types;
    typedef enum logic [1:0] {DMEM_IDLE, DMEM_BUSY, DMEM_HIT} dmem_state_t;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {ERR_NONE, ERR_ALIGN, ERR_RANGE, ERR_CONFLICT} dmem_err_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with synchronous write and combinational read
module dmem_array import datapath_types::*; #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IW = $clog2(DEPTH_WORDS)
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [IW-1:0] idx,
    input  word_t         wdata,
    output word_t         rdata
);
    word_t mem [DEPTH_WORDS];
    always_ff @(posedge CLK)
        if (we) mem[idx] <= wdata;
    assign rdata = mem[idx];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency word memory responder for the scalar load/store request interface
module dmem_responder import datapath_types::*; #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [ADDR_W-1:0] dmemaddr,
    input  logic [DATA_W-1:0] dmemstore,
    output logic [DATA_W-1:0] dmemload,
    output logic              dhit,
    output logic              derror,
    output logic              busy
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-3:0] DEPTH_IDX = (ADDR_W-2)'(DEPTH_WORDS);
    dmem_state_t state, next;
    dmem_err_t cap_cause, in_cause;
    logic [3:0] cnt, cnt_n;
    logic [ADDR_W-3:0] in_idx;
    logic [IW-1:0] cap_idx, c_idx;
    word_t cap_data, c_data, rdata;
    logic cap_write, c_write, c_err, req, idle, go_hit, we;
    assign req = dmemREN | dmemWEN;
    assign idle = state == DMEM_IDLE;
    assign in_idx = dmemaddr[ADDR_W-1:2];
    assign in_cause = (dmemREN & dmemWEN) ? ERR_CONFLICT :
                      (dmemaddr[1:0] != 2'b00) ? ERR_ALIGN :
                      (in_idx >= DEPTH_IDX) ? ERR_RANGE : ERR_NONE;
    always_comb begin
        next = state;
        cnt_n = cnt;
        case (state)
            DMEM_IDLE: if (req) begin
                next = (LATENCY == 1) ? DMEM_HIT : DMEM_BUSY;
                cnt_n = 4'(LATENCY - 1);
            end
            DMEM_BUSY: if (!req) next = DMEM_IDLE;
                else begin
                    cnt_n = cnt - 4'd1;
                    next = (cnt == 4'd1) ? DMEM_HIT : DMEM_BUSY;
                end
            default: next = DMEM_IDLE;
        endcase
    end
    // With LATENCY=1 the commit edge is also the capture edge, so use the live request
    assign c_idx = idle ? in_idx[IW-1:0] : cap_idx;
    assign c_data = idle ? word_t'(dmemstore) : cap_data;
    assign c_write = idle ? dmemWEN : cap_write;
    assign c_err = idle ? (in_cause != ERR_NONE) : (cap_cause != ERR_NONE);
    assign go_hit = next == DMEM_HIT;
    assign we = go_hit & c_write & ~c_err;
    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .IW(IW)) u_array (
        .CLK(CLK), .we(we), .idx(c_idx), .wdata(c_data), .rdata(rdata)
    );
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= DMEM_IDLE;
            cnt <= '0;
            cap_idx <= '0;
            cap_data <= '0;
            cap_write <= 1'b0;
            cap_cause <= ERR_NONE;
            dmemload <= '0;
        end else begin
            state <= next;
            cnt <= cnt_n;
            if (idle && req) begin
                cap_idx <= in_idx[IW-1:0];
                cap_data <= dmemstore;
                cap_write <= dmemWEN;
                cap_cause <= in_cause;
            end
            if (go_hit && (c_err || !c_write)) dmemload <= c_err ? '0 : DATA_W'(rdata);
        end
    end
    assign dhit = state == DMEM_HIT;
    assign derror = dhit && (cap_cause != ERR_NONE);
    assign busy = !idle;
    a_err_with_hit: assert property (@(posedge CLK) disable iff (!nRST) derror |-> dhit && cap_cause != ERR_NONE);
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: three responders (LATENCY 2, 3, 1) checked against a transaction-level model
module tb_dmem_responder;
    logic clk = 0, nrst = 0;
    logic ren[3], wen[3], hit_o[3], err_o[3], busy_o[3];
    logic [31:0] addr[3], store[3], load_o[3];
    bit hitc[3];
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    for (genvar j = 0; j < 3; j++) begin : g
        dmem_responder #(.LATENCY(j == 0 ? 2 : (j == 1 ? 3 : 1))) dut (
            .CLK(clk), .nRST(nrst), .dmemREN(ren[j]), .dmemWEN(wen[j]),
            .dmemaddr(addr[j]), .dmemstore(store[j]), .dmemload(load_o[j]),
            .dhit(hit_o[j]), .derror(err_o[j]), .busy(busy_o[j])
        );
    end
    function automatic int lat(input int k);
        return k == 0 ? 2 : (k == 1 ? 3 : 1);
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    // Model: a request held for LATENCY sampled cycles completes; the cycle after completion is dead
    int age[3];
    bit mhit[3], merr[3], lk[3], fr[3], fw[3], mv[3][1024];
    logic [31:0] eload[3], fa[3], fd[3], mm[3][1024];
    always @(posedge clk) begin
        logic rs;
        logic rr[3], ww[3];
        logic [31:0] aa[3], dd[3];
        rs = nrst;
        for (int k = 0; k < 3; k++) begin
            rr[k] = ren[k]; ww[k] = wen[k]; aa[k] = addr[k]; dd[k] = store[k];
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            if (!rs) begin
                age[k] = 0; mhit[k] = 0; merr[k] = 0; eload[k] = 0; lk[k] = 1;
            end else if (mhit[k]) begin
                mhit[k] = 0; age[k] = 0;
            end else if (rr[k] || ww[k]) begin
                if (age[k] == 0) begin
                    fr[k] = rr[k]; fw[k] = ww[k]; fa[k] = aa[k]; fd[k] = dd[k];
                end
                age[k]++;
                if (age[k] == lat(k)) begin
                    mhit[k] = 1; age[k] = 0;
                    merr[k] = fa[k][1:0] != 0 || (fa[k] >> 2) >= 1024 || (fr[k] && fw[k]);
                    if (merr[k]) begin
                        eload[k] = 0; lk[k] = 1;
                    end else if (fw[k]) begin
                        mm[k][fa[k][11:2]] = fd[k]; mv[k][fa[k][11:2]] = 1;
                    end else begin
                        lk[k] = mv[k][fa[k][11:2]]; eload[k] = mm[k][fa[k][11:2]];
                    end
                end
            end else age[k] = 0;
            chk($sformatf("model dhit[%0d]", k), hit_o[k], mhit[k]);
            chk($sformatf("model derror[%0d]", k), err_o[k], mhit[k] && merr[k]);
            chk($sformatf("model busy[%0d]", k), busy_o[k], age[k] > 0 || mhit[k]);
            if (lk[k]) chk($sformatf("model dmemload[%0d]", k), load_o[k], eload[k]);
        end
    end
    task automatic op(input int k, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] el, input bit ee, input bit ck);
        @(negedge clk);
        ren[k] = r; wen[k] = w; addr[k] = a; store[k] = d;
        if (hitc[k]) begin
            @(posedge clk); #1;
            chk($sformatf("gap dhit[%0d]", k), hit_o[k], 0);
            chk($sformatf("gap busy[%0d]", k), busy_o[k], 0);
        end
        for (int i = 1; i <= lat(k); i++) begin
            @(posedge clk); #1;
            chk($sformatf("op%0d a=%h dhit c%0d", k, a, i), hit_o[k], i == lat(k));
        end
        chk($sformatf("op%0d a=%h busy", k, a), busy_o[k], 1);
        chk($sformatf("op%0d a=%h derror", k, a), err_o[k], ee);
        if (ck) chk($sformatf("op%0d a=%h dmemload", k, a), load_o[k], el);
        hitc[k] = 1;
    endtask
    task automatic drop(input int k);
        @(negedge clk);
        ren[k] = 0; wen[k] = 0;
        @(posedge clk);
        hitc[k] = 0;
    endtask
    initial begin
        for (int k = 0; k < 3; k++) begin
            ren[k] = 0; wen[k] = 0; addr[k] = 0; store[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset dhit", hit_o[k], 0); chk("reset derror", err_o[k], 0);
            chk("reset busy", busy_o[k], 0); chk("reset dmemload", load_o[k], 0);
        end
        @(negedge clk) nrst = 1;
        op(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0);
        op(0, 1, 0, 32'h10, 0, 32'hDEADBEEF, 0, 1);
        drop(0);
        @(negedge clk);
        wen[0] = 1; addr[0] = 32'h40; store[0] = 32'h12345678;
        @(posedge clk);
        @(negedge clk) nrst = 0;
        #1;
        chk("midreset dhit", hit_o[0], 0); chk("midreset busy", busy_o[0], 0);
        chk("midreset derror", err_o[0], 0); chk("midreset dmemload", load_o[0], 0);
        wen[0] = 0;
        @(negedge clk) nrst = 1;
        op(0, 1, 0, 32'h40, 0, 0, 0, 0);
        checks++;
        if (load_o[0] === 32'h12345678) begin
            errors++;
            $display("FAIL discarded write visible: got %h expected not %h", load_o[0], 32'h12345678);
        end
        drop(0);
        op(0, 1, 0, 32'h10, 0, 32'hDEADBEEF, 0, 1); drop(0);
        op(0, 1, 0, 32'h13, 0, 0, 1, 1); drop(0);
        op(0, 1, 0, 32'h10, 0, 32'hDEADBEEF, 0, 1); drop(0);
        op(0, 1, 0, 32'h1000, 0, 0, 1, 1); drop(0);
        op(0, 0, 1, 32'h0, 32'hCAFEF00D, 0, 0, 0); drop(0);
        op(0, 1, 1, 32'h0, 32'h55, 0, 1, 1); drop(0);
        op(0, 1, 0, 32'h0, 0, 32'hCAFEF00D, 0, 1); drop(0);
        op(1, 0, 1, 32'h20, 32'h11111111, 0, 0, 0); drop(1);
        @(negedge clk);
        wen[1] = 1; addr[1] = 32'h20; store[1] = 32'hAAAA5555;
        @(negedge clk) wen[1] = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("abort dhit", hit_o[1], 0);
        end
        op(1, 1, 0, 32'h20, 0, 32'h11111111, 0, 1); drop(1);
        @(negedge clk);
        wen[1] = 1; addr[1] = 32'h24; store[1] = 32'h77;
        @(negedge clk);
        addr[1] = 32'h28; store[1] = 32'h99;
        repeat (2) @(posedge clk);
        #1 chk("held capture dhit", hit_o[1], 1);
        drop(1);
        op(1, 1, 0, 32'h24, 0, 32'h77, 0, 1); drop(1);
        op(2, 0, 1, 32'h0, 32'hA1, 0, 0, 0);
        op(2, 1, 0, 32'h0, 0, 32'hA1, 0, 1);
        op(2, 0, 1, 32'h4, 32'hB2, 0, 0, 0);
        op(2, 1, 0, 32'h4, 0, 32'hB2, 0, 1);
        op(2, 0, 1, 32'h0, 32'hC3, 0, 0, 0);
        op(2, 1, 0, 32'h0, 0, 32'hC3, 0, 1);
        op(2, 1, 0, 32'h4, 0, 32'hB2, 0, 1);
        drop(2);
        repeat (3) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
